// File: rtl/usb3_link_pkg.sv
// Shared link-layer constants and types for the USB3 TX arbiter.
package usb3_link_pkg;

    localparam int unsigned LINK_WORD_W = 32;
    localparam int unsigned LINK_K_W    = 4;

    localparam int unsigned REQ_LCMD = 0;
    localparam int unsigned REQ_HP   = 1;
    localparam int unsigned REQ_DPP  = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/usb3_tx_arb_pick.sv
// Combinational winner selection: promoted requesters first, then plain fixed priority.
module usb3_tx_arb_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [NUM_REQ-1:0] promoted_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_valid_o
);

    logic [NUM_REQ-1:0] cand;

    // Lowest-index candidate wins; a promoted requester only counts while it is valid.
    always_comb begin
        cand = valid_i & promoted_i;
        if (cand == '0) begin
            cand = valid_i;
        end
        winner_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner_o = IDX_W'(i);
            end
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/usb3_tx_arb.sv
// Link-layer TX arbiter: packet-atomic grants of the single PIPE link_out path.
// Optional build macro USB3_TX_ARB_IDLE_FILL_EN: drive logical idle with
// out_active high on cycles that carry no packet word.
module usb3_tx_arb
    import usb3_link_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned MAX_WORDS    = 259,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned IDX_W = $clog2(NUM_REQ),
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1),
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                            local_clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [LINK_WORD_W*NUM_REQ-1:0]  req_data,
    input  logic [LINK_K_W*NUM_REQ-1:0]     req_datak,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [LINK_WORD_W-1:0]          out_data,
    output logic [LINK_K_W-1:0]             out_datak,
    output logic                            out_active,
    input  logic                            out_stall,
    output logic                            out_skp_inhibit,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            err_overrun,
    output logic [IDX_W-1:0]                err_idx
);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STV_W-1:0]       starve_q [NUM_REQ];
    logic [STV_W-1:0]       starve_d [NUM_REQ];
    logic [NUM_REQ-1:0]     promoted;
    logic [IDX_W-1:0]       winner;
    logic                   any_valid;
    logic                   grant_now, accept, overrun;
    logic                   cur_valid, cur_last;
    logic [LINK_WORD_W-1:0] cur_data, data_q, data_d;
    logic [LINK_K_W-1:0]    cur_datak, datak_q, datak_d;
    logic                   active_q, active_d, skp_q, skp_d;
    logic                   in_pkt_q, in_pkt_d, last_out_q, last_out_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       err_idx_q, err_idx_d;

    usb3_tx_arb_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .valid_i    (req_valid),
        .promoted_i (promoted),
        .winner_o   (winner),
        .any_valid_o(any_valid)
    );

    // Select the current owner's word lane.
    always_comb begin
        cur_valid = req_valid[grant_q];
        cur_last  = req_last[grant_q];
        cur_data  = req_data[grant_q*LINK_WORD_W +: LINK_WORD_W];
        cur_datak = req_datak[grant_q*LINK_K_W +: LINK_K_W];
    end

    // Packet FSM: grant in IDLE, forward words in BUSY, swallow the runaway tail in DRAIN.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        grant_now = 1'b0;
        accept    = 1'b0;
        overrun   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_now = 1'b1;
                    grant_d   = winner;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                req_ready[grant_q] = !out_stall;
                accept             = cur_valid && !out_stall;
                if (accept) begin
                    if (cur_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(MAX_WORDS - 1)) begin
                        overrun = 1'b1;
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!cur_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A requester is promoted once its loss count saturates.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            promoted[i] = (starve_q[i] == STV_W'(STARVE_LIMIT));
        end
    end

    // Losers that were waiting age by one per grant; the winner starts fresh.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_d[i] = starve_q[i];
            if (grant_now) begin
                if (winner == IDX_W'(i)) begin
                    starve_d[i] = '0;
                end else if (req_valid[i] && !promoted[i]) begin
                    starve_d[i] = starve_q[i] + 1'b1;
                end
            end
        end
    end

    // Output word register, SKP inhibit window and overrun reporting.
    always_comb begin
        data_d     = data_q;
        datak_d    = datak_q;
        active_d   = active_q;
        in_pkt_d   = in_pkt_q;
        last_out_d = 1'b0;
        err_d      = overrun;
        err_idx_d  = overrun ? grant_q : err_idx_q;
        if (accept) begin
            data_d     = cur_data;
            datak_d    = cur_datak;
            active_d   = 1'b1;
            in_pkt_d   = !(cur_last || overrun);
            last_out_d = cur_last || overrun;
        end else if (out_stall) begin
            last_out_d = last_out_q;
        end else begin
`ifdef USB3_TX_ARB_IDLE_FILL_EN
            data_d   = '0;
            datak_d  = '0;
            active_d = 1'b1;
`else
            active_d = 1'b0;
`endif
        end
        // Covers the whole packet plus the cycle after its final word leaves the register.
        skp_d = accept || in_pkt_q || last_out_q || (out_stall && skp_q);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            datak_q    <= '0;
            active_q   <= 1'b0;
            skp_q      <= 1'b0;
            in_pkt_q   <= 1'b0;
            last_out_q <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            datak_q    <= datak_d;
            active_q   <= active_d;
            skp_q      <= skp_d;
            in_pkt_q   <= in_pkt_d;
            last_out_q <= last_out_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    assign out_data        = data_q;
    assign out_datak       = datak_q;
    assign out_active      = active_q;
    assign out_skp_inhibit = skp_q;
    assign grant_idx       = grant_q;
    assign err_overrun     = err_q;
    assign err_idx         = err_idx_q;

endmodule

// File: tb/tb_usb3_tx_arb.sv
// Self-checking bench for usb3_tx_arb: directed steps plus an output scoreboard.
module tb_usb3_tx_arb;
    import usb3_link_pkg::*;

    logic        local_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [95:0] req_data  = '0;
    logic [11:0] req_datak = '0;
    logic [2:0]  req_last  = '0;
    logic [2:0]  req_ready;
    logic [31:0] out_data;
    logic [3:0]  out_datak;
    logic        out_active;
    logic        out_stall = 1'b0;
    logic        out_skp_inhibit;
    logic [1:0]  grant_idx;
    logic        err_overrun;
    logic [1:0]  err_idx;

    usb3_tx_arb #(
        .NUM_REQ     (3),
        .MAX_WORDS   (8),
        .STARVE_LIMIT(4)
    ) dut (
        .local_clk      (local_clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_datak      (req_datak),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .out_data       (out_data),
        .out_datak      (out_datak),
        .out_active     (out_active),
        .out_stall      (out_stall),
        .out_skp_inhibit(out_skp_inhibit),
        .grant_idx      (grant_idx),
        .err_overrun    (err_overrun),
        .err_idx        (err_idx)
    );

    always #5 local_clk = ~local_clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [35:0] exp_q[$];
    logic [2:0]  acc_seen    = '0;
    int          first_acc[3];
    int          last_acc[3];
    int          pk_done[3];
    int          pk0_at[3];
    int          n_acc[3];

    always @(posedge local_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [31:0] base, input int n);
        logic [31:0] d;
        for (int w = 0; w < n; w++) begin
            d = base + 32'(w);
            exp_q.push_back({d, d[3:0]});
        end
    endtask

    task automatic drive(input int r, input logic [31:0] d, input logic l);
        req_valid[r]         = 1'b1;
        req_data[32*r +: 32] = d;
        req_datak[4*r +: 4]  = d[3:0];
        req_last[r]          = l;
    endtask

    // Accept is sampled by the monitor on the falling edge preceding the rising edge.
    task automatic wait_acc(input int r, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(posedge local_clk);
            #1;
            if (acc_seen[r]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input int r, input int n, input logic [31:0] base);
        bit ok;
        for (int w = 0; w < n; w++) begin
            drive(r, base + 32'(w), w == n - 1);
            wait_acc(r, 300, ok);
            if (!ok) begin
                chk("accept_timeout", 64'(ok), 64'd1);
                break;
            end
            n_acc[r]++;
            if (w == 0) begin
                first_acc[r] = cyc;
                pk0_at[r]    = pk_done[0];
            end
        end
        last_acc[r] = cyc;
        pk_done[r]++;
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    // Output monitor: every cycle is either a fresh word, a stall hold, or an idle cycle.
    initial begin
        logic [35:0] e;
        logic [37:0] prev;
        logic        stall_prev;
        prev       = '0;
        stall_prev = 1'b0;
        forever begin
            @(negedge local_clk);
            if (!reset_n) begin
                acc_seen   = '0;
                stall_prev = 1'b0;
            end else begin
                if (|acc_seen) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 36'bx;
                    chk("out_word", {out_active, out_data, out_datak}, {1'b1, e});
                end else if (stall_prev) begin
                    chk("stall_hold", {out_active, out_skp_inhibit, out_data, out_datak}, prev);
                end else begin
`ifdef USB3_TX_ARB_IDLE_FILL_EN
                    chk("idle_fill", {out_active, out_data, out_datak}, {1'b1, 36'h0});
`else
                    chk("idle_cycle", {out_active, out_data, out_datak}, {1'b0, prev[35:0]});
`endif
                end
                stall_prev = out_stall;
                acc_seen   = req_valid & req_ready;
            end
            prev = {out_active, out_skp_inhibit, out_data, out_datak};
        end
    end

    initial begin
        bit ok;
        int got;
        for (int i = 0; i < 3; i++) begin
            first_acc[i] = 0; last_acc[i] = 0; pk_done[i] = 0; pk0_at[i] = 0; n_acc[i] = 0;
        end

        // Reset state
        #1;
        chk("reset_outs", {out_data, out_datak, out_active, out_skp_inhibit, req_ready,
                           grant_idx, err_overrun, err_idx}, 64'h0);
        #20 reset_n = 1'b1;
        @(posedge local_clk); #1;

        // Single LCMD packet: latency and SKP inhibit window
        drive(REQ_LCMD, 32'h1111_1111, 1'b0);
        req_datak[3:0] = 4'hF;
        exp_q.push_back({32'h1111_1111, 4'hF});
        exp_q.push_back({32'h2222_2222, 4'hF});
        @(negedge local_clk) chk("lcmd_ready_t0", 64'(req_ready[0]), 64'd0);
        @(posedge local_clk); #1;
        @(negedge local_clk) chk("lcmd_ready_t1", {req_ready, grant_idx}, {3'b001, 2'd0});
        @(posedge local_clk); #1;
        drive(REQ_LCMD, 32'h2222_2222, 1'b1);
        req_datak[3:0] = 4'hF;
        @(negedge local_clk) chk("lcmd_w1", {out_data, out_active, out_skp_inhibit},
                                 {32'h1111_1111, 2'b11});
        @(posedge local_clk); #1;
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        @(negedge local_clk) chk("lcmd_w2", {out_data, out_active, out_skp_inhibit},
                                 {32'h2222_2222, 2'b11});
        @(posedge local_clk); #1;
        @(negedge local_clk) chk("lcmd_tail", {out_active, out_skp_inhibit}, 2'b01);
        @(posedge local_clk); #1;
        @(negedge local_clk) chk("lcmd_skp_off", 64'(out_skp_inhibit), 64'd0);
        @(posedge local_clk); #1;

        // Priority: HP beats DPP, DPP follows after one idle cycle
        push_pkt(32'h4000_0010, 5);
        push_pkt(32'h8000_0020, 5);
        fork
            send(REQ_HP, 5, 32'h4000_0010);
            send(REQ_DPP, 5, 32'h8000_0020);
        join
        chk("prio_order", 64'(first_acc[1] < first_acc[2]), 64'd1);
        chk("prio_gap", 64'(first_acc[2] - last_acc[1]), 64'd2);
        chk("prio_starve_clr", 64'(dut.starve_q[2]), 64'd0);
        repeat (2) @(posedge local_clk);
        #1;

        // Starvation: DPP promoted after four LCMD packets
        for (int p = 0; p < 4; p++) push_pkt(32'hA000_0000 + 32'(p * 16), 2);
        push_pkt(32'hC000_0040, 2);
        for (int p = 4; p < 6; p++) push_pkt(32'hA000_0000 + 32'(p * 16), 2);
        fork
            for (int p = 0; p < 6; p++) send(REQ_LCMD, 2, 32'hA000_0000 + 32'(p * 16));
            send(REQ_DPP, 2, 32'hC000_0040);
        join
        chk("starve_after_4", 64'(pk0_at[2]), 64'd4);
        repeat (2) @(posedge local_clk);
        #1;

        // Stall for three cycles mid-packet
        push_pkt(32'h5000_0100, 6);
        n_acc[1] = 0;
        fork
            send(REQ_HP, 6, 32'h5000_0100);
            begin
                for (int k = 0; k < 100 && n_acc[1] < 2; k++) begin
                    @(posedge local_clk); #1;
                end
                out_stall = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge local_clk);
                    chk("stall_ready", {req_ready, out_active, out_skp_inhibit}, {3'b000, 2'b11});
                    @(posedge local_clk); #1;
                end
                out_stall = 1'b0;
            end
        join
        repeat (3) @(posedge local_clk);
        #1;

        // Overrun: DPP streams 12 words without last, HP pending
        push_pkt(32'hD000_0200, 8);
        push_pkt(32'h6000_0300, 3);
        got = 0;
        for (int w = 0; w < 12; w++) begin
            drive(REQ_DPP, 32'hD000_0200 + 32'(w), 1'b0);
            wait_acc(REQ_DPP, 4, ok);
            if (!ok) break;
            got++;
            if (w == 0) drive(REQ_HP, 32'h6000_0300, 1'b0);
            if (w == 7) begin
                @(negedge local_clk) chk("ovr_pulse", {err_overrun, err_idx}, {1'b1, 2'd2});
                @(negedge local_clk) chk("ovr_pulse_end", 64'(err_overrun), 64'd0);
            end
        end
        chk("ovr_accepts", 64'(got), 64'd8);
        req_valid[2] = 1'b0;
        @(negedge local_clk) chk("drain_ready", 64'(req_ready), 64'd0);
        @(posedge local_clk); #1;
        @(negedge local_clk) chk("idle_ready", {req_ready, err_idx}, {3'b000, 2'd2});
        @(posedge local_clk); #1;
        @(negedge local_clk) chk("hp_after_drain", {req_ready, grant_idx}, {3'b010, 2'd1});
        send(REQ_HP, 3, 32'h6000_0300);
        repeat (2) @(posedge local_clk);
        #1;

        // Reset mid-packet: word 3 of a DPP never gets out
        push_pkt(32'hE000_0400, 1);
        drive(REQ_DPP, 32'hE000_0400, 1'b0);
        wait_acc(REQ_DPP, 10, ok);
        drive(REQ_DPP, 32'hE000_0401, 1'b0);
        wait_acc(REQ_DPP, 10, ok);
        drive(REQ_DPP, 32'hE000_0402, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset", {out_data, out_datak, out_active, out_skp_inhibit, req_ready,
                            grant_idx, err_overrun, err_idx}, 64'h0);
        req_valid = '0;
        req_last  = '0;
        @(negedge local_clk);
        #2 reset_n = 1'b1;
        chk("reset_flush", 64'(exp_q.size()), 64'd0);
        @(posedge local_clk); #1;
        push_pkt(32'h7000_0500, 2);
        send(REQ_HP, 2, 32'h7000_0500);
        repeat (3) @(posedge local_clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb3_tx_arb.md
Name: usb3_tx_arb

Overview:
- Link-layer transmit arbiter. It shares the single 32-bit link TX path (pipe link_out_* interface) between NUM_REQ packet sources: index 0 is link commands, 1 is header packets, 2 is data payload.
- Grants are packet-atomic, using fixed priority with a starvation guard.
- It honours PIPE stall, holds SKP inhibit across packets, and aborts runaway packets.
- It sits between the link-layer packet generators and the usb3_pipe link_out port, in the local_clk (125 MHz) domain.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has the highest priority.
- MAX_WORDS, 259, maximum words per packet before an abort (1024-byte DPP plus framing).
- STARVE_LIMIT, 4, number of consecutive packets a waiting requester may lose before it is promoted.

Ports:
- local_clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  word valid, per requester.
- req_data  in  32*NUM_REQ  word data; requester i uses bits [32i+31:32i].
- req_datak  in  4*NUM_REQ  K flags; requester i uses bits [4i+3:4i].
- req_last  in  NUM_REQ  marks the final word of a packet.
- req_ready  out  NUM_REQ  word accepted when valid & ready.
- out_data  out  32  to link_out_data.
- out_datak  out  4  to link_out_datak.
- out_active  out  1  to link_out_active.
- out_stall  in  1  from link_out_stall.
- out_skp_inhibit  out  1  to link_out_skp_inhibit.
- grant_idx  out  $clog2(NUM_REQ)  current owner; valid while busy.
- err_overrun  out  1  one-cycle pulse on abort.
- err_idx  out  $clog2(NUM_REQ)  owner at abort; holds until the next abort.

Behaviour:
- Reset: state IDLE; all outputs 0, including out_data, out_datak, req_ready, grant_idx, err_idx and all starvation counters.
- Reset asserted mid-packet clears everything immediately. No partial-packet recovery.

State machine:
- IDLE
  - If any req_valid is set, register the winner into grant_idx and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY
  - req_ready[grant_idx] = !out_stall. All other ready bits are 0.
  - On each accept, increment word_cnt (width $clog2(MAX_WORDS+1)).
  - Accept with req_last: go to IDLE and clear word_cnt.
  - Accept without req_last when word_cnt == MAX_WORDS-1: pulse err_overrun, latch err_idx, go to DRAIN.
- DRAIN
  - All ready bits are 0.
  - Return to IDLE after req_valid[grant_idx] has been low for one cycle.
  - Words arriving in DRAIN are never forwarded.

Arbitration:
- The lowest-index promoted requester wins. If none is promoted, the lowest-index valid requester wins.
- starve_cnt[i]:
  - increments, saturating at STARVE_LIMIT, when another requester is granted while req_valid[i] is high;
  - clears when i is granted;
  - i is promoted when starve_cnt[i] == STARVE_LIMIT.

Datapath:
- Output registers load on accept. Word accepted at cycle t appears on out_* at t+1 with out_active = 1.
- On a non-accept cycle with out_stall low, out_active = 0.
- While out_stall is high, out_data, out_datak and out_active all hold their values.
- First-word latency: valid at t, ready at t+1, on output at t+2.
- One idle cycle is mandatory between packets. Back-to-back packets show exactly one out_active = 0 cycle.
- out_skp_inhibit is registered. It is high from the cycle the first word is on the output until the cycle after the last word leaves the output register, including while stalled.
- Simultaneous last and stall: the last word is not accepted (ready is low) and is retried.

Optional Feature:
- Macro: USB3_TX_ARB_IDLE_FILL_EN.
- Defined: non-accept, non-stall cycles drive logical idle (out_data = 0, out_datak = 0) with out_active = 1.
- Undefined: those cycles drive out_active = 0, and out_data/out_datak hold their last value.

Decomposition:
- Package usb3_link_pkg holds:
  - constants LINK_WORD_W = 32 and LINK_K_W = 4;
  - requester indices REQ_LCMD = 0, REQ_HP = 1, REQ_DPP = 2;
  - typedef arb_state_t {IDLE, BUSY, DRAIN}.
- One natural sub-module, usb3_tx_arb_pick: combinational priority-plus-starvation picker. Inputs: req_valid, promoted vector. Outputs: winner index and any-valid.

Test Plan:
- Single LCMD: req 0 sends 2 words (0x1111_1111 then 0x2222_2222 with last, datak 0xF). Required: those words on out_* at t+2 and t+3, then out_active = 0; out_skp_inhibit high for the 2 output cycles plus 1.
- Priority: req 1 and req 2 valid together, each sending a 5-word packet. Required: req 1 is granted first, req 2 follows after exactly 1 idle cycle, and starve_cnt[2] is 0 after its grant.
- Starvation, STARVE_LIMIT = 4: req 0 sends continuous 2-word packets while req 2 stays valid. Required: req 2 is granted after exactly 4 req-0 packets.
- Stall: assert out_stall for 3 cycles in mid-packet. Required:
  - out_* hold their values;
  - req_ready is low for those 3 cycles;
  - no word is lost or duplicated;
  - out_skp_inhibit stays high.
- Overrun: MAX_WORDS = 8, req 2 streams 12 words with no last. Required:
  - err_overrun pulses after the 8th accept, with err_idx = 2;
  - no further words are forwarded;
  - the arbiter returns to IDLE one cycle after req_valid[2] drops;
  - a pending req 1 is then granted.
- Reset mid-packet: drop reset_n during word 3 of a DPP. Required: all outputs are 0 asynchronously, and after reset release a new packet arbitrates normally.
